// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : alu_pkg                                                      |
// | Purpose : Opcode encodings and FSM state type shared by the sequential |
// |           shift/rotate engine and its per-cycle step datapath.         |
// | Contents: OP_SLL/OP_SRL/OP_SRA/OP_ROL/OP_ROR opcodes, state_t          |
// |           (ST_IDLE/ST_RUN/ST_DONE), op_is_reserved() helper.           |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package alu_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Encodings 101..111 are reserved.
  function automatic logic op_is_reserved(input logic [2:0] op);
    return (op > OP_ROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_rotate_step.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : shift_rotate_step                                            |
// | Purpose : Combinational shift/rotate of data by 0..STEP bits, built as |
// |           a mux over every constant amount so depth stays bounded.     |
// | Ports   : data   in  WIDTH  operand                                    |
// |           op     in  3      opcode (reserved ops pass data through)    |
// |           step   in  SW     amount 0..STEP                             |
// |           result out WIDTH  shifted/rotated data                       |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module shift_rotate_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int STEP  = 8,
  localparam int SW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  input  logic [SW-1:0]    step,
  output logic [WIDTH-1:0] result
);

  // k is always a loop constant here, so every branch is a fixed rewire.
  function automatic logic [WIDTH-1:0] apply(input logic [WIDTH-1:0] d,
                                             input logic [2:0]       o,
                                             input int               k);
    logic signed [WIDTH-1:0] sd;
    sd = d;
    case (o)
      OP_SLL:  return d << k;
      OP_SRL:  return d >> k;
      OP_SRA:  return sd >>> k;
      OP_ROL:  return (d << k) | (d >> (WIDTH - k));
      OP_ROR:  return (d >> k) | (d << (WIDTH - k));
      default: return d;
    endcase
  endfunction

  always_comb begin
    result = data;
    for (int k = 1; k <= STEP; k++) begin
      if (int'(step) == k) result = apply(data, op, k);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_shift_rotate_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : seq_shift_rotate_unit                                        |
// | Purpose : Multi-cycle shift/rotate engine. The shift amount is consumed|
// |           in chunks of at most STEP bits per clock, with valid/ready   |
// |           handshakes on request and result sides.                      |
// | Ports   : clk, rst (sync, active-high)                                 |
// |           in_valid/in_ready, in_data[WIDTH], in_op[3], in_amt[AW]      |
// |           out_valid/out_ready, out_data[WIDTH], out_err                |
// |           busy (high while RUN or DONE)                                |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module seq_shift_rotate_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int STEP  = 8,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AW-1:0]    in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  localparam int SW = $clog2(STEP + 1);
  // STEP <= WIDTH = 2**AW, so AW+1 bits always hold it.
  localparam logic [AW:0] STEP_MAX = (AW + 1)'(STEP);

  state_t           state;
  logic [2:0]       op_q;
  logic [AW-1:0]    rem;
  logic [AW:0]      rem_ext;
  logic [AW:0]      step_full;
  logic [SW-1:0]    step;
  logic [AW-1:0]    rem_next;
  logic [WIDTH-1:0] stepped;
  logic             accept_reserved;

  assign rem_ext         = {1'b0, rem};
  assign step_full       = (rem_ext < STEP_MAX) ? rem_ext : STEP_MAX;
  assign step            = SW'(step_full);
  assign rem_next        = rem - AW'(step_full);
  assign accept_reserved = op_is_reserved(in_op);

  // Mask with rst so no request is taken on a reset edge.
  assign in_ready = (state == ST_IDLE) && !rst;

  // out_data doubles as the working register while in RUN.
  shift_rotate_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data   (out_data),
    .op     (op_q),
    .step   (step),
    .result (stepped)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_SLL;
      rem       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            out_data <= in_data;
            op_q     <= in_op;
            rem      <= in_amt;
            out_err  <= accept_reserved;
            busy     <= 1'b1;
            if ((in_amt == '0) || accept_reserved) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          out_data <= stepped;
          rem      <= rem_next;
          if (rem_next == '0) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
